// File: rtl/mul_unit.sv
// RV32M multiply unit: three-stage valid/ready pipeline around an
// unsigned 32x32 array, with sign handling on either side of it.
module multiplier32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);

    assign p = {32'd0, a} * {32'd0, b};

endmodule

module mul_unit #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b11;

    typedef struct packed {
        logic             sign_res;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
    } ctl_t;

    logic        s1_valid;
    ctl_t        s1_ctl;
    logic [31:0] s1_mag_a;
    logic [31:0] s1_mag_b;

    logic        s2_valid;
    ctl_t        s2_ctl;
    logic [63:0] s2_prod;

    logic        rdy1;
    logic        rdy2;
    logic        rdy3;
    logic        load1;
    logic        load2;
    logic        load3;

    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] prod;
    logic [63:0] full;

    // Each stage can take new data when empty or when it is draining.
    assign rdy3     = !out_valid || out_ready;
    assign rdy2     = !s2_valid || rdy3;
    assign rdy1     = !s1_valid || rdy2;
    assign in_ready = rdy1 && !flush;

    assign load1 = in_valid && in_ready;
    assign load2 = s1_valid && rdy2;
    assign load3 = s2_valid && rdy3;

    assign busy = s1_valid || s2_valid || out_valid;

    // MULHU treats a as unsigned; only MUL/MULH treat b as signed.
    always_comb begin
        sign_a = in_a[31] && (in_op != OP_MULHU);
        sign_b = in_b[31] && !in_op[1];
        mag_a  = sign_a ? (~in_a + 32'd1) : in_a;
        mag_b  = sign_b ? (~in_b + 32'd1) : in_b;
    end

    multiplier32 u_array (
        .a (s1_mag_a),
        .b (s1_mag_b),
        .p (prod)
    );

    assign full = s2_ctl.sign_res ? (~s2_prod + 64'd1) : s2_prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            out_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (rdy1) s1_valid <= in_valid;
            if (rdy2) s2_valid <= s1_valid;
            if (rdy3) out_valid <= s2_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_result <= '0;
            out_tag    <= '0;
        end else if (load3) begin
            out_result <= (s2_ctl.op == OP_MUL) ? full[31:0] : full[63:32];
            out_tag    <= s2_ctl.tag;
        end
    end

    always_ff @(posedge clk) begin
        if (load1) begin
            s1_ctl   <= '{sign_res: sign_a ^ sign_b, op: in_op, tag: in_tag};
            s1_mag_a <= mag_a;
            s1_mag_b <= mag_b;
        end
        if (load2) begin
            s2_ctl  <= s1_ctl;
            s2_prod <= prod;
        end
    end

endmodule
